// File: rtl/cr16_pkg.sv
// Shared definitions for the CompactRISC16 execute stage: opcodes, flag bit
// positions and the sequencer state encoding.
package cr16_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_ASHU = 4'd10;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cr16_iter_shifter.sv
// Bit-serial shifter: one position per step, with a down-counter of the
// remaining steps. The load itself performs the first shift.
module cr16_iter_shifter #(
  parameter int P_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               left,
  input  logic               arith,
  input  logic [P_WIDTH-1:0] data,
  input  logic [4:0]         count_init,
  output logic [P_WIDTH-1:0] value,
  output logic               zero
);

  logic [4:0] count;
  logic       left_q;
  logic       arith_q;

  function automatic logic [P_WIDTH-1:0] shift1(input logic [P_WIDTH-1:0] v,
                                                input logic l,
                                                input logic ar);
    if (l) return {v[P_WIDTH-2:0], 1'b0};
    return {ar & v[P_WIDTH-1], v[P_WIDTH-1:1]};
  endfunction

  // count_init is magnitude-1, since the load already moved one bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= '0;
      count   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value   <= shift1(data, left, arith);
      count   <= count_init;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && (count != 5'd0)) begin
      value <= shift1(value, left_q, arith_q);
      count <= count - 5'd1;
    end
  end

  assign zero = (count == 5'd0);

endmodule

// File: rtl/cr16_alu_seq.sv
// CompactRISC16 execute stage: single-cycle ALU ops, iterative shifts, and
// next-flags generation feeding the flag register.
module cr16_alu_seq
  import cr16_pkg::*;
#(
  parameter int P_WIDTH      = 16,
  parameter int P_FLAG_WIDTH = 5
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  input  logic                    I_START,
  input  logic [3:0]              I_OPCODE,
  input  logic [P_WIDTH-1:0]      I_A,
  input  logic [P_WIDTH-1:0]      I_B,
  input  logic [P_FLAG_WIDTH-1:0] I_FLAGS,
  output logic                    O_BUSY,
  output logic                    O_DONE,
  output logic [P_WIDTH-1:0]      O_RESULT,
  output logic                    O_WB,
  output logic [P_FLAG_WIDTH-1:0] O_FLAGS,
  output logic                    O_FLAGS_WE
);

  localparam int MSB = P_WIDTH - 1;

  state_t state_q, state_d;

  logic                    accept;
  logic                    is_shift;
  logic                    shift_go;
  logic [4:0]              count_init;
  logic [P_WIDTH-1:0]      sh_value;
  logic                    sh_zero;
  logic [P_FLAG_WIDTH-1:0] flags_lat;

  logic [P_WIDTH:0]        sum;
  logic [P_WIDTH:0]        diff;
  logic                    cin;
  logic                    add_ovf;
  logic                    sub_ovf;
  logic [P_WIDTH-1:0]      alu_result;
  logic [P_FLAG_WIDTH-1:0] alu_flags;
  logic                    alu_wb;
  logic                    alu_we;

  assign accept   = I_START && (state_q != ST_SHIFT);
  assign is_shift = (I_OPCODE == OP_LSH) || (I_OPCODE == OP_ASHU);
  assign shift_go = accept && is_shift && (I_B[4:0] != 5'd0);

  // |s|-1: s-1 for positive amounts, ~s for negative ones.
  assign count_init = I_B[4] ? ~I_B[4:0] : (I_B[4:0] - 5'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = shift_go ? ST_SHIFT : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (sh_zero) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign cin     = (I_OPCODE == OP_ADDC) ? I_FLAGS[FLAG_C] : 1'b0;
  assign sum     = {1'b0, I_A} + {1'b0, I_B} + {{P_WIDTH{1'b0}}, cin};
  assign diff    = {1'b0, I_A} - {1'b0, I_B};
  assign add_ovf = (I_A[MSB] == I_B[MSB]) && (sum[MSB] != I_A[MSB]);
  assign sub_ovf = (I_A[MSB] != I_B[MSB]) && (diff[MSB] != I_A[MSB]);

  always_comb begin
    alu_result = '0;
    alu_flags  = I_FLAGS;
    alu_wb     = 1'b1;
    alu_we     = 1'b0;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        alu_result        = sum[P_WIDTH-1:0];
        alu_flags[FLAG_C] = sum[P_WIDTH];
        alu_flags[FLAG_F] = add_ovf;
        alu_we            = 1'b1;
      end
      OP_ADDU: alu_result = sum[P_WIDTH-1:0];
      OP_SUB: begin
        alu_result        = diff[P_WIDTH-1:0];
        alu_flags[FLAG_C] = diff[P_WIDTH];
        alu_flags[FLAG_F] = sub_ovf;
        alu_we            = 1'b1;
      end
      OP_CMP: begin
        alu_result        = O_RESULT;
        alu_wb            = 1'b0;
        alu_we            = 1'b1;
        alu_flags[FLAG_L] = diff[P_WIDTH];
        alu_flags[FLAG_N] = $signed(I_A) < $signed(I_B);
        alu_flags[FLAG_Z] = (I_A == I_B);
      end
      OP_AND:  alu_result = I_A & I_B;
      OP_OR:   alu_result = I_A | I_B;
      OP_XOR:  alu_result = I_A ^ I_B;
      OP_MOV:  alu_result = I_B;
      OP_LSH, OP_ASHU: alu_result = I_A;
      default: alu_wb = 1'b0;
    endcase
  end

  cr16_iter_shifter #(.P_WIDTH(P_WIDTH)) u_shifter (
    .clk        (I_CLK),
    .reset      (I_RESET),
    .load       (shift_go),
    .step       (state_q == ST_SHIFT),
    .left       (~I_B[4]),
    .arith      (I_OPCODE == OP_ASHU),
    .data       (I_A),
    .count_init (count_init),
    .value      (sh_value),
    .zero       (sh_zero)
  );

  // Pulses default low; O_RESULT and O_FLAGS only move on a completion.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_BUSY     <= 1'b0;
      O_DONE     <= 1'b0;
      O_WB       <= 1'b0;
      O_FLAGS_WE <= 1'b0;
      O_RESULT   <= '0;
      O_FLAGS    <= '0;
      flags_lat  <= '0;
    end else begin
      O_BUSY     <= (state_d == ST_SHIFT);
      O_DONE     <= 1'b0;
      O_WB       <= 1'b0;
      O_FLAGS_WE <= 1'b0;
      if (shift_go) begin
        flags_lat <= I_FLAGS;
      end else if (accept) begin
        O_DONE     <= 1'b1;
        O_RESULT   <= alu_result;
        O_WB       <= alu_wb;
        O_FLAGS_WE <= alu_we;
        O_FLAGS    <= alu_flags;
      end else if ((state_q == ST_SHIFT) && sh_zero) begin
        O_DONE   <= 1'b1;
        O_RESULT <= sh_value;
        O_WB     <= 1'b1;
        O_FLAGS  <= flags_lat;
      end
    end
  end

endmodule

// File: tb/tb_cr16_alu_seq.sv
// Randomized scoreboard bench for cr16_alu_seq against an arithmetic
// reference model of the instruction set.
module tb_cr16_alu_seq;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_START;
  logic [3:0]  I_OPCODE;
  logic [15:0] I_A;
  logic [15:0] I_B;
  logic [4:0]  I_FLAGS;
  logic        O_BUSY;
  logic        O_DONE;
  logic [15:0] O_RESULT;
  logic        O_WB;
  logic [4:0]  O_FLAGS;
  logic        O_FLAGS_WE;

  logic        use_loop;
  logic [4:0]  flags_drv;
  logic [4:0]  model_flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] res;
    bit          chk_res;
    bit          wb;
    bit          we;
    logic [4:0]  flags;
    int          done_edge;
    int          busy_len;
  } exp_t;

  exp_t sb_q[$];

  assign I_FLAGS = use_loop ? O_FLAGS : flags_drv;

  always #5 I_CLK = ~I_CLK;

  cr16_alu_seq #(.P_WIDTH(16), .P_FLAG_WIDTH(5)) dut (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_START    (I_START),
    .I_OPCODE   (I_OPCODE),
    .I_A        (I_A),
    .I_B        (I_B),
    .I_FLAGS    (I_FLAGS),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_RESULT   (O_RESULT),
    .O_WB       (O_WB),
    .O_FLAGS    (O_FLAGS),
    .O_FLAGS_WE (O_FLAGS_WE)
  );

  // Index of the most recent rising edge (first posedge at t=5 is edge 0).
  function automatic int edge_now();
    return int'(($time - 5) / 10);
  endfunction

  function automatic int to_s16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input int a, input int b, input logic [4:0] fin);
    exp_t e;
    int sa, sb, r, sr, s, n, cin;
    sa = to_s16(a);
    sb = to_s16(b);
    e.res = 16'h0; e.chk_res = 1'b1; e.wb = 1'b1; e.we = 1'b0;
    e.flags = fin; e.busy_len = 0; e.done_edge = 0;
    case (op)
      0, 2: begin
        cin = (op == 2) ? int'(fin[0]) : 0;
        r  = a + b + cin;
        sr = sa + sb + cin;
        e.res = 16'(r);
        e.flags[0] = (r > 65535);
        e.flags[2] = (sr > 32767) || (sr < -32768);
        e.we = 1'b1;
      end
      1: e.res = 16'(a + b);
      3: begin
        r  = a - b;
        sr = sa - sb;
        e.res = 16'(r);
        e.flags[0] = (a < b);
        e.flags[2] = (sr > 32767) || (sr < -32768);
        e.we = 1'b1;
      end
      4: begin
        e.chk_res = 1'b0;
        e.wb = 1'b0;
        e.we = 1'b1;
        e.flags[1] = (a < b);
        e.flags[4] = (sa < sb);
        e.flags[3] = (a == b);
      end
      5: e.res = 16'(a & b);
      6: e.res = 16'(a | b);
      7: e.res = 16'(a ^ b);
      8: e.res = 16'(b);
      9, 10: begin
        s = b & 31;
        if (s >= 16) s = s - 32;
        n = (s < 0) ? -s : s;
        e.busy_len = n;
        if (s > 0)        r = a << n;
        else if (op == 10) r = sa >>> n;
        else              r = a >> n;
        e.res = 16'(r);
      end
      default: e.wb = 1'b0;
    endcase
    return e;
  endfunction

  // Waits for a non-busy cycle, drives the request and records the expected completion.
  task automatic applyStimulus(input int op, input int a, input int b, input bit junk,
                               input bit loop, input logic [4:0] fdrv);
    exp_t e;
    logic [4:0] fin;
    int waited = 0;
    @(negedge I_CLK);
    while (O_BUSY && waited < 40) begin
      if (junk) begin
        I_START  = 1'b1;
        I_OPCODE = 4'($urandom_range(0, 15));
        I_A      = 16'($urandom);
        I_B      = 16'($urandom);
      end else begin
        I_START = 1'b0;
      end
      waited++;
      @(negedge I_CLK);
    end
    if (O_BUSY) begin
      checks++;
      failures++;
      $display("[TB] FAIL busy_timeout: got busy=1 expected busy=0 within 40 cycles");
      I_START = 1'b0;
      return;
    end
    use_loop  = loop;
    flags_drv = fdrv;
    fin = loop ? model_flags : fdrv;
    e = model(op, a & 16'hFFFF, b & 16'hFFFF, fin);
    I_OPCODE = 4'(op);
    I_A      = 16'(a);
    I_B      = 16'(b);
    I_START  = 1'b1;
    @(posedge I_CLK);
    e.done_edge = edge_now() + e.busy_len;
    sb_q.push_back(e);
    model_flags = e.flags;
  endtask

  // Monitor: pops the scoreboard on every completion pulse.
  initial begin : monitor
    int busy_run;
    int cur;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge I_CLK);
      cur = edge_now();
      if (O_BUSY === 1'b1) busy_run++;
      if (O_DONE === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at edge %0d", cur);
        end else begin
          e = sb_q.pop_front();
          checkOutput("done_edge", cur, e.done_edge);
          checkOutput("busy_cycles", busy_run, e.busy_len);
          if (e.chk_res) checkOutput("result", {16'h0, O_RESULT}, {16'h0, e.res});
          checkOutput("wb", {31'h0, O_WB}, {31'h0, e.wb});
          checkOutput("flags_we", {31'h0, O_FLAGS_WE}, {31'h0, e.we});
          checkOutput("flags", {27'h0, O_FLAGS}, {27'h0, e.flags});
        end
      end else if (sb_q.size() > 0 && cur > sb_q[0].done_edge + 2) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_timeout: got no done expected done at edge %0d", sb_q[0].done_edge);
        void'(sb_q.pop_front());
      end
      if (O_BUSY !== 1'b1) busy_run = 0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish before t=400000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    I_RESET = 1'b1; I_START = 1'b0; I_OPCODE = 4'h0; I_A = 16'h0; I_B = 16'h0;
    use_loop = 1'b0; flags_drv = 5'h0; model_flags = 5'h0;
    repeat (2) @(posedge I_CLK);
    @(negedge I_CLK);
    checkOutput("reset_busy",     {31'h0, O_BUSY},     32'h0);
    checkOutput("reset_done",     {31'h0, O_DONE},     32'h0);
    checkOutput("reset_wb",       {31'h0, O_WB},       32'h0);
    checkOutput("reset_flags_we", {31'h0, O_FLAGS_WE}, 32'h0);
    checkOutput("reset_result",   {16'h0, O_RESULT},   32'h0);
    checkOutput("reset_flags",    {27'h0, O_FLAGS},    32'h0);
    I_RESET = 1'b0;

    $display("[TB] directed sequences");
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 5'b00000);
    applyStimulus(3, 16'h0000, 16'h0001, 1'b0, 1'b1, 5'b00000);
    applyStimulus(2, 16'h0000, 16'h0000, 1'b0, 1'b1, 5'b00000);
    applyStimulus(4, 16'h8000, 16'h0001, 1'b0, 1'b0, 5'b00001);
    applyStimulus(9, 16'h0001, 16'h000F, 1'b0, 1'b0, 5'b00001);
    applyStimulus(10, 16'h8000, 16'h0010, 1'b0, 1'b0, 5'b00001);
    applyStimulus(15, 16'h1234, 16'h5678, 1'b0, 1'b0, 5'b10101);

    // LSH n=10 aborted by a one-cycle reset sampled at edge 5 of the shift.
    applyStimulus(9, 16'h0001, 16'h000A, 1'b0, 1'b0, 5'b00001);
    repeat (4) @(posedge I_CLK);
    @(negedge I_CLK);
    I_START = 1'b0;
    I_RESET = 1'b1;
    sb_q.delete();
    @(posedge I_CLK);
    #1;
    I_RESET = 1'b0;
    model_flags = 5'h0;
    checkOutput("abort_busy",     {31'h0, O_BUSY},     32'h0);
    checkOutput("abort_done",     {31'h0, O_DONE},     32'h0);
    checkOutput("abort_wb",       {31'h0, O_WB},       32'h0);
    checkOutput("abort_flags_we", {31'h0, O_FLAGS_WE}, 32'h0);
    checkOutput("abort_result",   {16'h0, O_RESULT},   32'h0);
    checkOutput("abort_flags",    {27'h0, O_FLAGS},    32'h0);
    applyStimulus(0, 16'h0102, 16'h0304, 1'b0, 1'b1, 5'b00000);

    // START pulsed through an n=4 shift: only the one in the DONE cycle counts.
    applyStimulus(9, 16'h00F1, 16'h0004, 1'b0, 1'b1, 5'b00000);
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 5'b00000);
    applyStimulus(10, 16'h8421, 16'h001D, 1'b0, 1'b1, 5'b00000);
    applyStimulus(8, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 5'b00000);

    $display("[TB] randomized sequence");
    for (int i = 0; i < 150; i++) begin
      int op, a, b;
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 65535);
      b  = $urandom_range(0, 65535);
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1 ? 16'h8000 : 16'h7FFF};
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)));
    end

    @(negedge I_CLK);
    I_START = 1'b0;
    repeat (25) @(negedge I_CLK);
    checkOutput("scoreboard_empty", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr16_alu_seq.md
# cr16_alu_seq

Sequencing ALU execute stage for CompactRISC16: it accepts one operation per handshake, computes the 16-bit result, and produces the full 5-bit next-flags vector plus a write strobe. It sits directly upstream of `cr16_flags`. `O_FLAGS`/`O_FLAGS_WE` connect to its `I_FLAGS`/`I_ENABLE`, and its `O_FLAGS` loops back to `I_FLAGS` here. Arithmetic and logic ops complete in one cycle; `LSH`/`ASHU` shift one bit per cycle.

## Interface
- `P_WIDTH`, 16, datapath width
- `P_FLAG_WIDTH`, 5, flag vector width; must match `cr16_flags`
- `I_CLK`  in  1  clock
- `I_RESET`  in  1  reset; one clock, reset is synchronous and active-high
- `I_START`  in  1  request; accepted on a rising edge when `O_BUSY`=0
- `I_OPCODE`  in  4  0 ADD, 1 ADDU, 2 ADDC, 3 SUB, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 MOV, 9 LSH, 10 ASHU, 11–15 illegal
- `I_A`  in  P_WIDTH  Rdest operand
- `I_B`  in  P_WIDTH  Rsrc/immediate; shifts use `I_B[4:0]` as a signed amount
- `I_FLAGS`  in  P_FLAG_WIDTH  current flag register value
- `O_BUSY`  out  1  shift in progress
- `O_DONE`  out  1  one-cycle completion pulse
- `O_RESULT`  out  P_WIDTH  result; holds until the next completion
- `O_WB`  out  1  result write-back valid; pulses with `O_DONE`
- `O_FLAGS`  out  P_FLAG_WIDTH  next flags; bit order [0]C [1]L [2]F [3]Z [4]N
- `O_FLAGS_WE`  out  1  flag write strobe; pulses with `O_DONE`

## Operation
- FSM states:
  - `IDLE`: `I_START` latches opcode, operands and `I_FLAGS`. Non-shift op or shift amount 0 → `DONE`. Shift amount ≠ 0 → `SHIFT`.
  - `SHIFT`: one bit per cycle; down-counter of the remaining magnitude; counter reaching 0 → `DONE`.
  - `DONE`: one cycle; asserts the output pulses. `I_START` in this cycle is accepted, with the same transitions as `IDLE`; otherwise → `IDLE`.
- Arithmetic is modulo 2^16. C is the carry-out of the 17-bit sum. F is signed overflow.
- Flag updates; bits not listed are copied from the latched `I_FLAGS`:
  - ADD: C, F
  - ADDC: A+B+`I_FLAGS[0]`; C, F
  - SUB: A−B; C = borrow (A<B unsigned); F = signed overflow
  - CMP: `O_WB`=0; L = A<B unsigned, N = A<B signed, Z = A==B
- No flag write (`O_FLAGS_WE`=0, `O_FLAGS` = latched value): ADDU, AND, OR, XOR, MOV, LSH, ASHU.
- Shifts:
  - Amount s = signed `I_B[4:0]`: s>0 shifts left, s<0 shifts right, magnitude n = |s|, range 0..16.
  - LSH fills with zeros. ASHU fills right shifts with the sign bit and left shifts with zeros.
  - n=16 shifts fully out: 0x0000, or 0xFFFF for ASHU with a negative operand.
- Illegal opcode: completes in one cycle; `O_RESULT`=0, `O_WB`=0, `O_FLAGS_WE`=0.
- `I_START` while `O_BUSY`=1 is ignored; there is no queueing.

## Timing
- Edge 0 is the edge that samples an accepted `I_START`.
- Single-cycle ops: `O_DONE`, `O_WB`, `O_FLAGS_WE` and `O_RESULT` are registered at edge 0, i.e. visible in the next cycle.
- Shift with magnitude n:
  - `O_BUSY` is high in the cycles following edges 0..n−1.
  - `O_DONE` is registered at edge n.
  - n=0 behaves as single-cycle.
- Back-to-back: a `START` in the `DONE` cycle gives 1 op/cycle throughput for non-shift ops.
- Reset:
  - FSM → `IDLE`.
  - `O_BUSY`, `O_DONE`, `O_WB`, `O_FLAGS_WE` = 0; `O_RESULT` = 0; `O_FLAGS` = 0.
  - Reset mid-shift aborts the operation: no `O_DONE` and no flag write.
  - `I_START` sampled on the edge after reset deasserts is accepted.
- Reset takes priority over `I_START` on the same edge.

## Structure
- Shared package `cr16_pkg` holds:
  - opcode constants
  - flag bit indices (`C`, `L`, `F`, `Z`, `N`)
  - FSM state encoding
- One sub-module, `cr16_iter_shifter`: 16-bit shift register plus 5-bit magnitude down-counter, with load/step/direction/arithmetic inputs and a zero-count output. The FSM, adder/compare logic and flag merge stay in `cr16_alu_seq`.

## Test plan
- ADD A=0x7FFF B=0x0001, `I_FLAGS`=0 → after edge 0: `O_RESULT`=0x8000, `O_WB`=1, `O_FLAGS_WE`=1, `O_FLAGS`=5'b00100.
- SUB A=0x0000 B=0x0001 then ADDC A=0x0000 B=0x0000 fed back-to-back, with `O_FLAGS` looped to `I_FLAGS` → 0xFFFF with C=1; then 0x0001 with C=0, F=0.
- CMP A=0x8000 B=0x0001, `I_FLAGS`=5'b00001 → `O_WB`=0, `O_FLAGS`=5'b10001 (N=1, L=0, Z=0, C preserved).
- Shift amounts and latency:
  - LSH A=0x0001 B=0x000F → `O_BUSY` high 15 cycles; `O_DONE` at edge 15 with 0x8000; `O_FLAGS_WE`=0.
  - ASHU A=0x8000 B=0x0010 (s=−16) → `O_DONE` at edge 16 with 0xFFFF.
- LSH n=10 with `I_RESET` asserted at edge 5 → no `O_DONE`; all outputs 0. A following ADD completes normally.
- `I_START` pulsed every cycle during an n=4 shift → ignored until the `DONE` cycle. The `START` in the `DONE` cycle is accepted and completes next cycle.
